// File: rtl/delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// delay_line_ctrl
//
// Runtime-programmable fixed-latency delay line. Every cycle the pair
// {din_vld, din} is written into a circular buffer of MAX_DELAY entries. The
// word written cur_delay cycles earlier is read back and registered onto
// dout/dout_vld.
//
// After reset, or after an accepted delay change, the buffer may hold stale
// words. A two-state FSM (FILL/RUN) keeps the outputs at zero until every
// buffer slot that can be read holds a sample taken after the event.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous reset, active-high; overrides cfg_load
//   cfg_delay  : requested delay in cycles (legal range 1..MAX_DELAY)
//   cfg_load   : one-cycle strobe that samples cfg_delay
//   din        : input data word, captured every cycle
//   din_vld    : input qualifier, delayed alongside din (gaps preserved)
//   dout       : delayed data, 0 while masked
//   dout_vld   : delayed qualifier, 0 while masked
//   cur_delay  : active delay value
//   busy       : 1 while the FSM is in FILL (doubles as the FSM state view)
//   cfg_err    : one-cycle pulse after a rejected cfg_load
//
// Flow control: there is no backpressure. din/din_vld are sampled on every
// rising edge. din_vld is carried as data, so dout_vld reproduces the input
// valid pattern exactly, cur_delay cycles later.
// -----------------------------------------------------------------------------
module delay_line_ctrl #(
  parameter int WIDTH         = 32,
  parameter int MAX_DELAY     = 64,
  parameter int DEFAULT_DELAY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(MAX_DELAY+1)-1:0] cfg_delay,
  input  logic                           cfg_load,
  input  logic [WIDTH-1:0]               din,
  input  logic                           din_vld,
  output logic [WIDTH-1:0]               dout,
  output logic                           dout_vld,
  output logic [$clog2(MAX_DELAY+1)-1:0] cur_delay,
  output logic                           busy,
  output logic                           cfg_err
);

  localparam int DW = $clog2(MAX_DELAY + 1);  // delay / counter width
  localparam int AW = $clog2(MAX_DELAY);      // buffer address width
  localparam int XW = AW + 2;                 // read-address arithmetic width

  localparam logic [DW-1:0] MAX_D     = DW'(MAX_DELAY);
  localparam logic [DW-1:0] DEFAULT_D = DW'(DEFAULT_DELAY);
  localparam logic [AW-1:0] LAST_PTR  = AW'(MAX_DELAY - 1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [DW-1:0]    fill_cnt_q,  fill_cnt_d;
  logic [DW-1:0]    cur_delay_q, cur_delay_d;
  logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [WIDTH-1:0] dout_q,      dout_d;
  logic             dout_vld_q,  dout_vld_d;
  logic             cfg_err_q,   cfg_err_d;

  // Buffer word is {valid, data}. Not reset: FILL masks whatever it holds.
  logic [WIDTH:0]   mem_q [MAX_DELAY];
  logic [WIDTH:0]   mem_wdata_d;
  logic [WIDTH:0]   mem_rdata;

  logic             cfg_ok;
  logic             cfg_accept;
  logic             cfg_reject;

  logic [XW-1:0]    wr_ext;
  logic [XW-1:0]    dly_ext;
  logic [XW-1:0]    rd_full;
  logic [AW-1:0]    rd_addr;

  // ---------------------------------------------------------------------------
  // Configuration decode
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_ok     = (cfg_delay != '0) && (cfg_delay <= MAX_D);
    cfg_accept = cfg_load && cfg_ok;
    cfg_reject = cfg_load && !cfg_ok;
  end

  // ---------------------------------------------------------------------------
  // Buffer addressing
  // The slot written D edges ago sits at (wr_ptr - D) mod MAX_DELAY. When
  // D == MAX_DELAY this is the slot being overwritten at this edge. The read
  // is combinational and the write lands at the edge, so the old word is
  // still seen.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ext  = XW'(wr_ptr_q);
    dly_ext = XW'(cur_delay_q);
    if (wr_ext >= dly_ext) begin
      rd_full = wr_ext - dly_ext;
    end else begin
      rd_full = wr_ext + XW'(MAX_DELAY) - dly_ext;
    end
    rd_addr   = AW'(rd_full);
    mem_rdata = mem_q[rd_addr];
  end

  always_comb begin
    mem_wdata_d = {din_vld, din};
    if (wr_ptr_q == LAST_PTR) begin
      wr_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    cur_delay_d = cur_delay_q;
    dout_d      = '0;
    dout_vld_d  = 1'b0;
    cfg_err_d   = cfg_reject;

    unique case (state_q)
      ST_FILL: begin
        // Leave FILL once cur_delay fresh samples have been written. The
        // first word read in RUN is then the one taken at the first FILL edge.
        if (fill_cnt_q == cur_delay_q - DW'(1)) begin
          state_d    = ST_RUN;
          fill_cnt_d = '0;
        end else begin
          fill_cnt_d = fill_cnt_q + DW'(1);
        end
      end
      ST_RUN: begin
        {dout_vld_d, dout_d} = mem_rdata;
      end
      default: begin
        state_d    = ST_FILL;
        fill_cnt_d = '0;
      end
    endcase

    // An accepted load restarts FILL from this edge and masks the output
    // at this same edge, including when the FSM is already in FILL.
    if (cfg_accept) begin
      state_d     = ST_FILL;
      fill_cnt_d  = '0;
      cur_delay_d = cfg_delay;
      dout_d      = '0;
      dout_vld_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      fill_cnt_q  <= '0;
      cur_delay_q <= DEFAULT_D;
      wr_ptr_q    <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      cur_delay_q <= cur_delay_d;
      wr_ptr_q    <= wr_ptr_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // The buffer keeps writing through reset. Anything written then is masked
  // by the FILL that follows.
  always_ff @(posedge clk) begin
    mem_q[wr_ptr_q] <= mem_wdata_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign cur_delay = cur_delay_q;
  assign busy      = (state_q == ST_FILL);
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_delay_line_ctrl
//
// Drives delay_line_ctrl one edge at a time. The reference model keeps the
// full history of sampled inputs. For each edge it also tracks the active
// delay and the first edge at which the output becomes trustworthy. The
// expected output after edge e is history[e - delay] once e reaches that
// edge, and zero before it.
// -----------------------------------------------------------------------------
module tb_delay_line_ctrl;

  localparam int WIDTH         = 32;
  localparam int MAX_DELAY     = 64;
  localparam int DEFAULT_DELAY = 1;
  localparam int DW            = $clog2(MAX_DELAY + 1);

  // ---------------------------------------------------------------------------
  // Clock / DUT
  // ---------------------------------------------------------------------------
  logic             clk;
  logic             rst;
  logic [DW-1:0]    cfg_delay;
  logic             cfg_load;
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [DW-1:0]    cur_delay;
  logic             busy;
  logic             cfg_err;

  delay_line_ctrl #(
    .WIDTH         (WIDTH),
    .MAX_DELAY     (MAX_DELAY),
    .DEFAULT_DELAY (DEFAULT_DELAY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_delay (cfg_delay),
    .cfg_load  (cfg_load),
    .din       (din),
    .din_vld   (din_vld),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .cur_delay (cur_delay),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  int               tests_run    = 0;
  int               tests_failed = 0;

  logic [WIDTH-1:0] hist_d [$];
  logic             hist_v [$];
  int               m_delay = DEFAULT_DELAY;
  int               m_start = 0;
  logic             m_err   = 1'b0;
  int               e       = 0;

  logic [WIDTH-1:0] exp_d;
  logic             exp_v;
  logic             exp_busy;
  logic [DW-1:0]    exp_cur;

  // One clock edge: apply inputs, update the model with what was sampled,
  // then check every output 1 time unit after the edge.
  task automatic step(input logic r, input logic ld, input int dl,
                      input logic [WIDTH-1:0] d, input logic v);
    rst       = r;
    cfg_load  = ld;
    cfg_delay = dl[DW-1:0];
    din       = d;
    din_vld   = v;
    @(posedge clk);
    hist_d.push_back(d);
    hist_v.push_back(v);
    e = hist_d.size() - 1;

    if (r) begin
      m_delay = DEFAULT_DELAY;
      m_start = e + DEFAULT_DELAY + 1;
      m_err   = 1'b0;
    end else if (ld && dl >= 1 && dl <= MAX_DELAY) begin
      m_delay = dl;
      m_start = e + dl + 1;
      m_err   = 1'b0;
    end else begin
      m_err = ld;
    end

    if (e >= m_start) begin
      exp_d = hist_d[e - m_delay];
      exp_v = hist_v[e - m_delay];
    end else begin
      exp_d = '0;
      exp_v = 1'b0;
    end
    exp_busy = (e < m_start - 1);
    exp_cur  = m_delay[DW-1:0];

    #1;
    tests_run++;
    assert (dout === exp_d) else begin
      tests_failed++;
      $error("FAIL dout edge %0d: got %h expected %h", e, dout, exp_d);
    end
    tests_run++;
    assert (dout_vld === exp_v) else begin
      tests_failed++;
      $error("FAIL dout_vld edge %0d: got %b expected %b", e, dout_vld, exp_v);
    end
    tests_run++;
    assert (busy === exp_busy) else begin
      tests_failed++;
      $error("FAIL busy edge %0d: got %b expected %b", e, busy, exp_busy);
    end
    tests_run++;
    assert (cur_delay === exp_cur) else begin
      tests_failed++;
      $error("FAIL cur_delay edge %0d: got %0d expected %0d", e, cur_delay, exp_cur);
    end
    tests_run++;
    assert (cfg_err === m_err) else begin
      tests_failed++;
      $error("FAIL cfg_err edge %0d: got %b expected %b", e, cfg_err, m_err);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed + randomized sequence
  // ---------------------------------------------------------------------------
  logic pat [6];

  initial begin
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1; cfg_load = 1'b0; cfg_delay = '0; din = '0; din_vld = 1'b0;

    // Reset; a load coincident with reset must be dropped.
    step(1'b1, 1'b0, 0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 7, 32'hdead_beef, 1'b1);

    // Default delay of 1 with an incrementing stream.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, WIDTH'(i + 1), 1'b1);

    // Change to delay 5 while running.
    step(1'b0, 1'b1, 5, $urandom, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 0, $urandom, 1'($urandom_range(0, 1)));

    // Rejected loads: 0 and MAX_DELAY+1 must not disturb the stream.
    step(1'b0, 1'b1, 0, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, $urandom, 1'b1);
    step(1'b0, 1'b1, MAX_DELAY + 1, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, $urandom, 1'b1);

    // Full depth with a repeating gap pattern across many pointer wraps.
    step(1'b0, 1'b1, MAX_DELAY, $urandom, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 0, $urandom, pat[i % 6]);

    // Restart FILL with a shorter delay mid-fill.
    step(1'b0, 1'b1, 10, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, $urandom, 1'b1);
    step(1'b0, 1'b1, 3, $urandom, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, $urandom, 1'b1);

    // Reset mid-stream at delay 8; pre-reset data must never reappear.
    step(1'b0, 1'b1, 8, $urandom, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 0, $urandom, 1'b1);
    step(1'b1, 1'b0, 0, $urandom, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 0, $urandom, 1'b1);

    // Random mix of loads (legal and illegal), rare resets, random data.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, MAX_DELAY + 2)),
           $urandom,
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
